// File: rtl/systolic_job_scheduler_pkg.sv
// rtl/systolic_job_scheduler_pkg.sv - shared states and width helpers for the systolic job scheduler
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COLLECT,
    ST_RESPOND,
    ST_DRAIN
  } sched_state_e;

  function automatic int acc_width(input int din_width);
    return 2 * din_width;
  endfunction

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/systolic_job_scheduler_if.sv
// rtl/systolic_job_scheduler_if.sv - requester and response handshake bundle
interface systolic_job_scheduler_if #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4,
  parameter int NUM_REQ   = 2
) ();
  localparam int ID_W  = systolic_pkg::id_width(NUM_REQ);
  localparam int ACC_W = systolic_pkg::acc_width(DIN_WIDTH);

  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ-1:0]                       req_ready;
  logic [NUM_REQ-1:0][N-1:0][DIN_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][N-1:0][DIN_WIDTH-1:0] req_b;
  logic                                     rsp_valid;
  logic                                     rsp_ready;
  logic [ID_W-1:0]                          rsp_id;
  logic [N-1:0][ACC_W-1:0]                  rsp_data;
  logic                                     rsp_err;
  logic                                     rsp_short;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_short
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_short
  );

endinterface

// File: rtl/systolic_job_scheduler_rr_arbiter.sv
// rtl/systolic_job_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import systolic_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               found
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/systolic_job_scheduler.sv
// rtl/systolic_job_scheduler.sv - shares one systolic MAC array between requesters, one job at a time
module systolic_job_scheduler
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH   = 8,
  parameter int N           = 4,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4 * N + 8,
  parameter int DRAIN_CYC   = 2 * N + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  systolic_job_scheduler_if.slave       bus,
  output logic [N-1:0][DIN_WIDTH-1:0]   arr_a_din,
  output logic [N-1:0][DIN_WIDTH-1:0]   arr_b_din,
  output logic                          arr_in_valid,
  input  logic [2*DIN_WIDTH-1:0]        arr_c_out,
  input  logic                          arr_out_valid,
  output logic                          busy,
  output logic                          stray_beat
);

  localparam int ACC_W  = acc_width(DIN_WIDTH);
  localparam int ID_W   = id_width(NUM_REQ);
  localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;
  localparam int BC_W   = $clog2(N + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int DRN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  sched_state_e                state_q, state_d;
  logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [N-1:0][DIN_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [N-1:0][ACC_W-1:0]     res_q, res_d;
  logic [BC_W-1:0]             beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d, tmo_nxt;
  logic [DRN_W-1:0]            drain_cnt_q, drain_cnt_d;
  logic                        err_q, err_d;
  logic                        short_q, short_d;
  logic                        stray_q, stray_d;

  logic [NUM_REQ-1:0]          grant;
  logic [ID_W-1:0]             grant_idx;
  logic                        grant_found;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (grant_found)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    beat_cnt_d  = beat_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    short_d     = short_q;
    tmo_nxt     = tmo_cnt_q + TMO_W'(1);
    stray_d     = arr_out_valid && (state_q != ST_WAIT) && (state_q != ST_COLLECT);

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          a_d      = bus.req_a[grant_idx];
          b_d      = bus.req_b[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The ISSUE cycle itself counts as cycle 1 of the timeout window.
        beat_cnt_d = '0;
        tmo_cnt_d  = TMO_W'(1);
        res_d      = '0;
        err_d      = 1'b0;
        short_d    = 1'b0;
        state_d    = ST_WAIT;
      end

      ST_WAIT, ST_COLLECT: begin
        tmo_cnt_d = tmo_nxt;
        if (arr_out_valid && (beat_cnt_q < BC_W'(N))) begin
          res_d[beat_cnt_q[SLOT_W-1:0]] = arr_c_out;
          beat_cnt_d                    = beat_cnt_q + BC_W'(1);
        end
        if (state_q == ST_WAIT) begin
          if (arr_out_valid) begin
            state_d = (beat_cnt_d == BC_W'(N)) ? ST_RESPOND : ST_COLLECT;
          end
        end else if (!arr_out_valid) begin
          short_d = 1'b1;
          state_d = ST_RESPOND;
        end else if (beat_cnt_d == BC_W'(N)) begin
          state_d = ST_RESPOND;
        end
        // A beat landing in the timeout cycle is already in res_d above.
        if (tmo_nxt == TMO_W'(TIMEOUT_CYC)) begin
          err_d   = 1'b1;
          short_d = (beat_cnt_d < BC_W'(N));
          state_d = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          drain_cnt_d = '0;
          state_d     = err_q ? ST_DRAIN : ST_IDLE;
        end
      end

      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRN_W'(1);
        if (drain_cnt_q == DRN_W'(DRAIN_CYC - 1)) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      beat_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      short_q     <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      beat_cnt_q  <= beat_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      short_q     <= short_d;
      stray_q     <= stray_d;
    end
  end

  // Gated by rst_n so a requester held valid through reset sees no accept.
  assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign bus.rsp_valid = (state_q == ST_RESPOND);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = res_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_short = short_q;

  assign arr_a_din     = a_q;
  assign arr_b_din     = b_q;
  assign arr_in_valid  = (state_q == ST_ISSUE);
  assign busy          = (state_q != ST_IDLE);
  assign stray_beat    = stray_q;

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// tb/tb_systolic_job_scheduler.sv - directed self-checking bench for systolic_job_scheduler
module tb_systolic_job_scheduler;

  localparam int DW        = 8;
  localparam int N         = 4;
  localparam int NR        = 2;
  localparam int EXP_TMO   = 24;
  localparam int EXP_DRAIN = 10;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0][DW-1:0]   arr_a_din, arr_b_din;
  logic                   arr_in_valid;
  logic [2*DW-1:0]        arr_c_out;
  logic                   arr_out_valid;
  logic                   busy;
  logic                   stray_beat;

  systolic_job_scheduler_if #(.DIN_WIDTH(DW), .N(N), .NUM_REQ(NR)) bus ();

  systolic_job_scheduler #(.DIN_WIDTH(DW), .N(N), .NUM_REQ(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .arr_a_din     (arr_a_din),
    .arr_b_din     (arr_b_din),
    .arr_in_valid  (arr_in_valid),
    .arr_c_out     (arr_c_out),
    .arr_out_valid (arr_out_valid),
    .busy          (busy),
    .stray_beat    (stray_beat)
  );

  int tests_run;
  int tests_failed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Array model: after each start pulse waits mdl_lat cycles, then streams mdl_nbeats beats.
  int                   mdl_nbeats;
  int                   mdl_lat;
  logic [15:0]          mdl_vals [8];
  logic [N-1:0][DW-1:0] mdl_last_a, mdl_last_b;
  logic                 mdl_busy;

  initial begin
    arr_out_valid = 1'b0;
    arr_c_out     = '0;
    mdl_busy      = 1'b0;
    mdl_last_a    = '0;
    mdl_last_b    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (arr_in_valid === 1'b1) begin
        mdl_busy   = 1'b1;
        mdl_last_a = arr_a_din;
        mdl_last_b = arr_b_din;
        repeat (mdl_lat) begin
          @(posedge clk);
          #1;
        end
        for (int k = 0; k < mdl_nbeats; k++) begin
          arr_out_valid = 1'b1;
          arr_c_out     = mdl_vals[k];
          @(posedge clk);
          #1;
        end
        arr_out_valid = 1'b0;
        arr_c_out     = '0;
        mdl_busy      = 1'b0;
      end
    end
  end

  int rdy_viol;
  int stray_cnt;

  initial begin
    rdy_viol  = 0;
    stray_cnt = 0;
    forever begin
      @(negedge clk);
      if ($countones(bus.req_ready) > 1) rdy_viol++;
      if (bus.req_ready != '0 && busy) rdy_viol++;
      if (stray_beat) stray_cnt++;
    end
  end

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_ops(input int r, input int base);
    for (int k = 0; k < N; k++) begin
      bus.req_a[r][k] = DW'(base + k);
      bus.req_b[r][k] = DW'(base + k);
    end
  endtask

  task automatic set_vals(input int n, input int v0, input int inc);
    mdl_nbeats = n;
    for (int k = 0; k < 8; k++) mdl_vals[k] = 16'(v0 + k * inc);
  endtask

  task automatic offer(input int r);
    int c;
    bus.req_valid    = '0;
    bus.req_valid[r] = 1'b1;
    #1;
    c = 0;
    while (bus.req_ready[r] !== 1'b1 && c < 200) begin
      step();
      c++;
    end
    check_eq("offer_grant", 64'(bus.req_ready[r]), 64'd1);
    step();
    bus.req_valid = '0;
  endtask

  task automatic get_rsp(output logic [63:0] id, output logic [63:0] data,
                         output logic [63:0] err, output logic [63:0] short_f);
    int c;
    bus.rsp_ready = 1'b1;
    c = 0;
    while (bus.rsp_valid !== 1'b1 && c < 200) begin
      step();
      c++;
    end
    check_eq("rsp_seen", 64'(bus.rsp_valid), 64'd1);
    id      = 64'(bus.rsp_id);
    data    = 64'(bus.rsp_data);
    err     = 64'(bus.rsp_err);
    short_f = 64'(bus.rsp_short);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] id, data, err, short_f, snap;
    int          k, d, c, n, viol, base_v, base_s;
    int          g [3];

    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    mdl_lat       = 2;
    set_vals(4, 1, 1);
    apply_reset();

    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_arr_in_valid", 64'(arr_in_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);

    // 1: single job
    set_vals(4, 10, 10);
    set_ops(0, 1);
    offer(0);
    check_eq("t1_pulse", 64'(arr_in_valid), 64'd1);
    get_rsp(id, data, err, short_f);
    check_eq("t1_id", id, 64'd0);
    check_eq("t1_data", data, 64'h0028_001E_0014_000A);
    check_eq("t1_err", err, 64'd0);
    check_eq("t1_short", short_f, 64'd0);
    check_eq("t1_arr_a", 64'(mdl_last_a), 64'h0403_0201);
    check_eq("t1_arr_b", 64'(mdl_last_b), 64'h0403_0201);

    // 2: both requesters valid from reset
    apply_reset();
    set_vals(4, 1, 1);
    set_ops(0, 2);
    set_ops(1, 3);
    base_v        = rdy_viol;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    n = 0;
    c = 0;
    while (n < 3 && c < 400) begin
      if (bus.req_ready != '0) begin
        g[n] = (bus.req_ready == 2'b10) ? 1 : 0;
        n++;
      end
      step();
      c++;
    end
    bus.req_valid = '0;
    check_eq("t2_grants", 64'(n), 64'd3);
    check_eq("t2_g0", 64'(g[0]), 64'd0);
    check_eq("t2_g1", 64'(g[1]), 64'd1);
    check_eq("t2_g2", 64'(g[2]), 64'd0);
    c = 0;
    while (busy && c < 200) begin
      step();
      c++;
    end
    check_eq("t2_idle", 64'(busy), 64'd0);
    check_eq("t2_ready_rules", 64'(rdy_viol - base_v), 64'd0);

    // 3: response backpressure
    bus.rsp_ready = 1'b0;
    set_vals(4, 'h1111, 'h1111);
    set_ops(1, 'h10);
    offer(1);
    c = 0;
    while (bus.rsp_valid !== 1'b1 && c < 100) begin
      step();
      c++;
    end
    check_eq("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("t3_id", 64'(bus.rsp_id), 64'd1);
    check_eq("t3_data", 64'(bus.rsp_data), 64'h4444_3333_2222_1111);
    snap          = 64'(bus.rsp_data);
    bus.req_valid = 2'b11;
    viol          = 0;
    repeat (20) begin
      step();
      if (bus.rsp_valid !== 1'b1 || 64'(bus.rsp_data) !== snap || bus.req_ready !== 2'b00)
        viol++;
    end
    check_eq("t3_hold_stable", 64'(viol), 64'd0);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step();
    check_eq("t3_done", 64'(busy), 64'd0);

    // 4: array never answers -> timeout, then drain
    bus.rsp_ready = 1'b0;
    set_vals(0, 0, 0);
    set_ops(0, 'h50);
    offer(0);
    check_eq("t4_issue", 64'(arr_in_valid), 64'd1);
    k = 0;
    while (bus.rsp_valid !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check_eq("t4_timeout_cycles", 64'(k), 64'(EXP_TMO));
    check_eq("t4_err", 64'(bus.rsp_err), 64'd1);
    check_eq("t4_data", 64'(bus.rsp_data), 64'd0);
    set_vals(4, 'h0B01, 1);
    set_ops(1, 'h60);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 1'b1;
    step();
    d = 0;
    while (bus.req_ready == '0 && d < 100) begin
      d++;
      step();
    end
    check_eq("t4_drain_cycles", 64'(d), 64'(EXP_DRAIN));
    check_eq("t4_next_grant", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    get_rsp(id, data, err, short_f);
    check_eq("t4_next_id", id, 64'd1);
    check_eq("t4_next_data", data, 64'h0B04_0B03_0B02_0B01);
    check_eq("t4_next_err", err, 64'd0);

    // 5: short burst, then over-long burst
    base_s = stray_cnt;
    set_vals(3, 'h0101, 'h0101);
    set_ops(0, 'h70);
    offer(0);
    get_rsp(id, data, err, short_f);
    check_eq("t5a_short", short_f, 64'd1);
    check_eq("t5a_err", err, 64'd0);
    check_eq("t5a_data", data, 64'h0000_0303_0202_0101);
    repeat (4) step();
    check_eq("t5a_no_stray", 64'(stray_cnt - base_s), 64'd0);
    base_s = stray_cnt;
    set_vals(6, 'hA1, 1);
    offer(0);
    get_rsp(id, data, err, short_f);
    check_eq("t5b_short", short_f, 64'd0);
    check_eq("t5b_data", data, 64'h00A4_00A3_00A2_00A1);
    repeat (4) step();
    check_eq("t5b_stray_beats", 64'(stray_cnt - base_s), 64'd2);

    // 6: reset in the middle of COLLECT
    set_vals(4, 'h0D01, 1);
    set_ops(1, 'h20);
    offer(1);
    c = 0;
    while (arr_out_valid !== 1'b1 && c < 50) begin
      step();
      c++;
    end
    check_eq("t6_beat_seen", 64'(arr_out_valid), 64'd1);
    step();
    step();
    check_eq("t6_in_job", 64'(busy), 64'd1);
    bus.req_valid = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ctrl",
             64'({busy, bus.rsp_valid, arr_in_valid, stray_beat, bus.rsp_err,
                  bus.rsp_short, bus.req_ready, bus.rsp_id}), 64'd0);
    check_eq("t6_rst_arr_a", 64'(arr_a_din), 64'd0);
    check_eq("t6_rst_data", 64'(bus.rsp_data), 64'd0);
    bus.req_valid = '0;
    c = 0;
    while (mdl_busy && c < 20) begin
      step();
      c++;
    end
    check_eq("t6_model_idle", 64'(mdl_busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    set_vals(4, 'h0C01, 1);
    set_ops(0, 'h30);
    set_ops(1, 'h40);
    bus.req_valid = 2'b11;
    #1;
    check_eq("t6_grant_req0", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = '0;
    get_rsp(id, data, err, short_f);
    check_eq("t6_id", id, 64'd0);
    check_eq("t6_data", data, 64'h0C04_0C03_0C02_0C01);
    check_eq("t6_err", err, 64'd0);
    check_eq("t6_short", short_f, 64'd0);
    check_eq("t6_arr_a", 64'(mdl_last_a), 64'h3332_3130);
    check_eq("all_ready_rules", 64'(rdy_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
